// File: rtl/oled_receiver.sv
// ----------------------------------------------------------------------------
// oled_receiver
//   Display-side receiver for the OLED serial link. Deserialises the
//   nCS/DnC/SDIN/SCLK stream (MSB first, SCLK sampled on its rising edge)
//   and decodes the set-column (0x15), set-row (0x75) and write-pixels
//   (0x5C) commands. It keeps the column/row window and pixel address, and
//   pulses pixel_valid once per completed two-byte colour.
//
// Ports
//   HCLK, HRESETn          system clock, asynchronous active-low reset
//   nCS, DnC, SDIN, SCLK   serial link inputs, synchronous to HCLK
//   byte_valid/_data/_dnc  one-cycle pulse plus last completed byte and DnC
//   pixel_valid/_x/_y/_colour  one-cycle pulse plus written pixel
//   col_start/col_end/row_start/row_end  current address window
//   cmd_error              one-cycle pulse: unknown command or stray data
// ----------------------------------------------------------------------------
module oled_receiver #(
    parameter int CoordWidth  = 7,
    parameter int ColourWidth = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   nCS,
    input  logic                   DnC,
    input  logic                   SDIN,
    input  logic                   SCLK,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_dnc,
    output logic                   pixel_valid,
    output logic [CoordWidth-1:0]  pixel_x,
    output logic [CoordWidth-1:0]  pixel_y,
    output logic [ColourWidth-1:0] pixel_colour,
    output logic [CoordWidth-1:0]  col_start,
    output logic [CoordWidth-1:0]  col_end,
    output logic [CoordWidth-1:0]  row_start,
    output logic [CoordWidth-1:0]  row_end,
    output logic                   cmd_error
);

    typedef enum logic [2:0] {
        IDLE,
        COL_ARG0,
        COL_ARG1,
        ROW_ARG0,
        ROW_ARG1,
        PIX_HI,
        PIX_LO
    } state_t;

    state_t                 state_q, state_d;
    logic                   sclk_q, sclk_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             hi_q, hi_d;
    logic [CoordWidth-1:0]  x_q, x_d, y_q, y_d;
    logic [CoordWidth-1:0]  cs_q, cs_d, ce_q, ce_d, rs_q, rs_d, re_q, re_d;
    logic                   bv_q, bv_d, bdnc_q, bdnc_d;
    logic [7:0]             bd_q, bd_d;
    logic                   pv_q, pv_d, err_q, err_d;
    logic [CoordWidth-1:0]  px_q, px_d, py_q, py_d;
    logic [ColourWidth-1:0] pc_q, pc_d;

    logic                   bit_edge;
    logic [7:0]             byte_w;
    logic [CoordWidth-1:0]  arg_w;

    assign bit_edge = SCLK & ~sclk_q & ~nCS;
    // The 8th bit completes the byte in the same cycle it is sampled, so the
    // decoder works on the shift register contents plus the incoming bit.
    assign byte_w   = {shift_q, SDIN};
    assign arg_w    = CoordWidth'(byte_w[6:0]);

    always_comb begin
        sclk_d  = SCLK;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        state_d = state_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        cs_d    = cs_q;
        ce_d    = ce_q;
        rs_d    = rs_q;
        re_d    = re_q;
        bv_d    = 1'b0;
        bd_d    = bd_q;
        bdnc_d  = bdnc_q;
        pv_d    = 1'b0;
        px_d    = px_q;
        py_d    = py_q;
        pc_d    = pc_q;
        err_d   = 1'b0;

        if (nCS) begin
            cnt_d = '0;
        end else if (bit_edge) begin
            shift_d = byte_w[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                bv_d   = 1'b1;
                bd_d   = byte_w;
                bdnc_d = DnC;
                if (!DnC) begin
                    unique case (byte_w)
                        8'h15: state_d = COL_ARG0;
                        8'h75: state_d = ROW_ARG0;
                        8'h5C: begin
                            state_d = PIX_HI;
                            x_d     = cs_q;
                            y_d     = rs_q;
                        end
                        default: begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    unique case (state_q)
                        IDLE:     err_d = 1'b1;
                        COL_ARG0: begin cs_d = arg_w; state_d = COL_ARG1; end
                        COL_ARG1: begin ce_d = arg_w; state_d = IDLE;     end
                        ROW_ARG0: begin rs_d = arg_w; state_d = ROW_ARG1; end
                        ROW_ARG1: begin re_d = arg_w; state_d = IDLE;     end
                        PIX_HI:   begin hi_d = byte_w; state_d = PIX_LO;  end
                        PIX_LO: begin
                            pv_d    = 1'b1;
                            px_d    = x_q;
                            py_d    = y_q;
                            pc_d    = ColourWidth'({hi_q, byte_w});
                            state_d = PIX_HI;
                            // Raster advance inside the window; +1 wraps
                            // modulo 2^CoordWidth so start>end is legal.
                            if (x_q == ce_q) begin
                                x_d = cs_q;
                                y_d = (y_q == re_q) ? rs_q : y_q + 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            hi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cs_q    <= '0;
            ce_q    <= '1;
            rs_q    <= '0;
            re_q    <= '1;
            bv_q    <= 1'b0;
            bd_q    <= '0;
            bdnc_q  <= 1'b0;
            pv_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cs_q    <= cs_d;
            ce_q    <= ce_d;
            rs_q    <= rs_d;
            re_q    <= re_d;
            bv_q    <= bv_d;
            bd_q    <= bd_d;
            bdnc_q  <= bdnc_d;
            pv_q    <= pv_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign byte_valid   = bv_q;
    assign byte_data    = bd_q;
    assign byte_dnc     = bdnc_q;
    assign pixel_valid  = pv_q;
    assign pixel_x      = px_q;
    assign pixel_y      = py_q;
    assign pixel_colour = pc_q;
    assign col_start    = cs_q;
    assign col_end      = ce_q;
    assign row_start    = rs_q;
    assign row_end      = re_q;
    assign cmd_error    = err_q;

endmodule

// File: tb/tb_oled_receiver.sv
module tb_oled_receiver;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       nCS = 1'b1;
    logic       DnC = 1'b0;
    logic       SDIN = 1'b0;
    logic       SCLK = 1'b0;
    logic       byte_valid, byte_dnc, pixel_valid, cmd_error;
    logic [7:0] byte_data;
    logic [6:0] pixel_x, pixel_y, col_start, col_end, row_start, row_end;
    logic [15:0] pixel_colour;

    int tests = 0;
    int fails = 0;

    oled_receiver #(.CoordWidth(7), .ColourWidth(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .nCS(nCS), .DnC(DnC), .SDIN(SDIN),
        .SCLK(SCLK), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_dnc(byte_dnc), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .pixel_colour(pixel_colour),
        .col_start(col_start), .col_end(col_end), .row_start(row_start),
        .row_end(row_end), .cmd_error(cmd_error)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- reference model (spec-level) ----------------
    // Decoder mode names follow the command protocol, not any encoding.
    int m_mode;   // 0 idle,1 col arg a,2 col arg b,3 row arg a,4 row arg b,5 colour hi,6 colour lo
    int cs, ce, rs, re, mx, my, hi;
    logic [8:0]  bq[$];   // {dnc, byte}
    logic [29:0] pq[$];   // {x, y, colour}
    int err_pending = 0;

    task automatic model_reset();
        m_mode = 0; cs = 0; ce = 127; rs = 0; re = 127; mx = 0; my = 0; hi = 0;
    endtask

    task automatic model_byte(input int b, input bit dnc);
        logic [7:0] bb;
        bb = b[7:0];
        bq.push_back({dnc, bb});
        if (!dnc) begin
            if (b == 'h15) m_mode = 1;
            else if (b == 'h75) m_mode = 3;
            else if (b == 'h5C) begin m_mode = 5; mx = cs; my = rs; end
            else begin m_mode = 0; err_pending++; end
        end else begin
            case (m_mode)
                0: err_pending++;
                1: begin cs = b % 128; m_mode = 2; end
                2: begin ce = b % 128; m_mode = 0; end
                3: begin rs = b % 128; m_mode = 4; end
                4: begin re = b % 128; m_mode = 0; end
                5: begin hi = b; m_mode = 6; end
                default: begin
                    logic [6:0] xx, yy;
                    logic [7:0] hh;
                    xx = mx[6:0]; yy = my[6:0]; hh = hi[7:0];
                    pq.push_back({xx, yy, hh, bb});
                    if (mx == ce) begin
                        mx = cs;
                        my = (my == re) ? rs : (my + 1) % 128;
                    end else mx = (mx + 1) % 128;
                    m_mode = 5;
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (byte_valid) begin
                if (bq.size() == 0) check("unexpected byte_valid", 1, 0);
                else check("byte", {byte_dnc, byte_data}, bq.pop_front());
            end
            if (pixel_valid) begin
                if (pq.size() == 0) check("unexpected pixel_valid", 1, 0);
                else check("pixel {x,y,colour}", {pixel_x, pixel_y, pixel_colour}, pq.pop_front());
            end
            if (cmd_error) begin
                if (err_pending == 0) check("unexpected cmd_error", 1, 0);
                else begin
                    err_pending--;
                    check("cmd_error", 1, 1);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_bits(input logic [7:0] b, input int n, input bit dnc);
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            SCLK = 1'b0; SDIN = b[7-i]; DnC = dnc; nCS = 1'b0;
            @(negedge HCLK);
            SCLK = 1'b1;
        end
    endtask

    task automatic send_byte(input int b, input bit dnc);
        model_byte(b, dnc);
        send_bits(b[7:0], 8, dnc);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || pq.size() != 0 || err_pending != 0) && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        @(negedge HCLK);
        check("pending bytes", bq.size(), 0);
        check("pending pixels", pq.size(), 0);
        check("pending errors", err_pending, 0);
    endtask

    task automatic check_window();
        drain();
        check("col_start", col_start, cs);
        check("col_end", col_end, ce);
        check("row_start", row_start, rs);
        check("row_end", row_end, re);
    endtask

    task automatic check_reset_values();
        check("rst byte_valid", byte_valid, 0);
        check("rst byte_data", byte_data, 0);
        check("rst byte_dnc", byte_dnc, 0);
        check("rst pixel_valid", pixel_valid, 0);
        check("rst pixel_x", pixel_x, 0);
        check("rst pixel_y", pixel_y, 0);
        check("rst pixel_colour", pixel_colour, 0);
        check("rst cmd_error", cmd_error, 0);
        check("rst col_start", col_start, 0);
        check("rst col_end", col_end, 127);
        check("rst row_start", row_start, 0);
        check("rst row_end", row_end, 127);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0; SCLK = 1'b0; nCS = 1'b1;
        model_reset();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        int r, k;
        model_reset();
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check_reset_values();

        // set column
        send_byte('h15, 0); send_byte('h0E, 1); send_byte('h15, 1);
        check_window();
        check("col_start=14", col_start, 14);
        check("col_end=21", col_end, 21);

        // full block plus one wrapping pixel
        send_byte('h75, 0); send_byte('h1F, 1); send_byte('h2B, 1);
        send_byte('h5C, 0);
        for (int i = 0; i < 105; i++) begin
            send_byte('h06, 1); send_byte('h3C, 1);
        end
        check_window();

        // abort partial byte
        send_bits(8'hA5, 5, 0);
        @(negedge HCLK); nCS = 1'b1;
        repeat (2) @(negedge HCLK);
        send_byte('h75, 0); send_byte('h33, 1); send_byte('hC0, 1);
        check_window();

        // errors
        send_byte('hAF, 0); send_byte('h12, 1);
        check_window();

        // pixel interrupted by command
        send_byte('h5C, 0); send_byte('hFF, 1); send_byte('h15, 0);
        send_byte('h05, 1); send_byte('h90, 1);
        check_window();

        // reset mid-pixel
        send_byte('h5C, 0); send_byte('h12, 1);
        drain();
        send_bits(8'h34, 4, 1);
        do_reset();
        @(negedge HCLK);
        check_reset_values();
        send_byte('h5C, 0); send_byte('hAB, 1); send_byte('hCD, 1);
        check_window();

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin send_byte('h15, 0); send_byte($urandom_range(0, 255), 1); send_byte($urandom_range(0, 255), 1); end
                2, 3: begin send_byte('h75, 0); send_byte($urandom_range(0, 255), 1); send_byte($urandom_range(0, 255), 1); end
                4: begin
                    k = $urandom_range(0, 255);
                    if (k == 'h15 || k == 'h75 || k == 'h5C) k = 'hAF;
                    send_byte(k, 0);
                end
                5: send_byte($urandom_range(0, 255), 1);
                6: begin
                    send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom));
                    @(negedge HCLK); nCS = 1'b1;
                    @(negedge HCLK);
                end
                default: begin
                    send_byte('h5C, 0);
                    k = $urandom_range(1, 6);
                    for (int j = 0; j < k; j++) begin
                        send_byte($urandom_range(0, 255), 1);
                        send_byte($urandom_range(0, 255), 1);
                    end
                end
            endcase
            if (n % 10 == 9) check_window();
        end
        check_window();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oled_receiver.md
# oled_receiver

Serial-display receiver for the OLED link: deserialises the nCS/DnC/SDIN/SCLK stream produced by the OLED manager and decodes the SSD1351-style command subset (0x15 set column, 0x75 set row, 0x5C write pixels). It maintains the column/row window and pixel address pointer and emits one pixel-write strobe per completed 16-bit colour. It serves as the display-side model in chip-level simulation and as a synthesizable frame-capture front end.

## Interface
Parameters:
- CoordWidth, 7: width of x/y coordinates and window registers (128×128 panel).
- ColourWidth, 16: pixel colour width, received as two bytes, MSB first.

Ports:
- HCLK  input  1  system clock; one clock only.
- HRESETn  input  1  reset, asynchronous, active-low.
- nCS  input  1  chip select, active-low; synchronous to HCLK.
- DnC  input  1  0 = command byte, 1 = data byte.
- SDIN  input  1  serial data, MSB first.
- SCLK  input  1  serial clock, synchronous to HCLK; sampled on 0→1 transition.
- byte_valid  output  1  one-cycle pulse: byte completed.
- byte_data  output  8  last completed byte.
- byte_dnc  output  1  DnC of last completed byte.
- pixel_valid  output  1  one-cycle pulse: pixel written.
- pixel_x  output  CoordWidth  column of pixel written.
- pixel_y  output  CoordWidth  row of pixel written.
- pixel_colour  output  ColourWidth  {high byte, low byte}.
- col_start, col_end, row_start, row_end  output  CoordWidth each  current window.
- cmd_error  output  1  one-cycle pulse: unknown command or unexpected data byte.

## Operation
- Edge detect: register sclk_q; bit_edge = SCLK & !sclk_q & !nCS.
- On bit_edge: shift SDIN into shift register and increment 3-bit bit counter. On the 8th edge, DnC is sampled, the byte is complete, and the decoder acts on it.
- nCS high: clear bit counter and discard any partial byte. Decoder state, window and address are retained.
- Decoder states: Idle, ColArg0, ColArg1, RowArg0, RowArg1, PixHi, PixLo.
- Command byte (DnC=0), in any state:
  - 0x15 → ColArg0.
  - 0x75 → RowArg0.
  - 0x5C → PixHi; load x←col_start, y←row_start.
  - Any other value → Idle with cmd_error.
  - A pending PixHi byte is discarded.
- Data byte (DnC=1):
  - ColArg0: col_start←byte[6:0], then ColArg1.
  - ColArg1: col_end←byte[6:0], then Idle.
  - RowArg0/RowArg1: same pattern for row_start/row_end.
  - PixHi: latch high byte, then PixLo.
  - PixLo: emit pixel at (x,y) with {hi,lo}, advance the address, then PixHi.
  - Idle: cmd_error; byte otherwise ignored.
- Address advance:
  - If x==col_end: x←col_start, and if y==row_end then y←row_start, else y←y+1.
  - Otherwise x←x+1.
  - Arithmetic is modulo 2^CoordWidth (127+1=0). start>end is legal and wraps through 0.
- Bit 7 of argument bytes is ignored.

## Timing
- Reset values:
  - All pulses 0; byte_data 0; byte_dnc 0; pixel_x/y 0; pixel_colour 0.
  - col_start 0, col_end 127, row_start 0, row_end 127.
  - State Idle; bit counter 0; sclk_q 0.
- Completion latency: byte_valid, pixel_valid and cmd_error are registered and assert for exactly one cycle, the cycle after the HCLK edge that samples the 8th bit.
- Window outputs update in that same following cycle.
- Minimum SCLK: 1 cycle high, 1 cycle low. The manager's ChangeData/SendData cadence (2 cycles per bit) gives one byte per ≥16 cycles.
- SCLK held high for multiple cycles counts as one edge.
- An SCLK rising edge coincident with nCS high is ignored.
- Reset asserted mid-byte or mid-pixel: everything returns to reset values immediately; no pulse is generated.

## Test plan
- Reset, then idle inputs for 20 cycles → all outputs at reset values, no pulses.
- Send 0x15 (DnC=0), 0x0E, 0x15 (DnC=1) → three byte_valid pulses with byte_dnc 0,1,1; col_start=14, col_end=21; state Idle; no cmd_error.
- Full block: SetX 0x0E/0x15, SetY 0x1F/0x2B, 0x5C, then 104 × {0x06,0x3C}:
  - pixel_valid pulses 104 times, colour 0x063C.
  - First pixel (14,31), 8th pixel (21,31), 9th pixel (14,32), last pixel (21,43).
  - A 105th pixel lands at (14,31).
- Abort: 5 SCLK edges, then nCS high for 2 cycles, then byte 0x75 → exactly one byte_valid with data 0x75; state RowArg0.
- Errors:
  - Command 0xAF → cmd_error pulse.
  - A following data byte 0x12 → second cmd_error pulse; window unchanged.
- Pixel interrupt: 0x5C, data 0xFF, then command 0x15 → no pixel_valid; state ColArg0.
- Reset asserted mid-pixel, then released → reset values, and the next 0x5C starts at (0,0).
